// File: rtl/oled_pkg.sv
// oled_pkg: shared definitions for the OLED I2C arbiter slice.
//   arb_state_t     - arbiter FSM states
//   OLED_*_ADDR     - SSD1306-style control-byte addresses (command / data)
//   OLED_NREQ, OLED_GAP_CYCLES, OLED_TIMEOUT - default arbiter parameters
//   idx_width()     - width of an index into an n-entry vector (min 1)
package oled_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ISSUE     = 2'd1,
    ST_WAIT_DONE = 2'd2,
    ST_GAP       = 2'd3
  } arb_state_t;

  localparam logic [15:0] OLED_CMD_ADDR  = 16'h0000;
  localparam logic [15:0] OLED_DATA_ADDR = 16'h0040;

  localparam int unsigned OLED_NREQ       = 3;
  localparam int unsigned OLED_GAP_CYCLES = 16;
  localparam int unsigned OLED_TIMEOUT    = 5000;
  localparam int unsigned OLED_WAIT_W     = 14;

  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/oled_rr_pick.sv
// oled_rr_pick: combinational round-robin selector.
//   i_elig  - eligible requesters
//   i_last  - index of the previous grant; search starts at i_last+1
//   o_grant - one-hot grant (zero when nothing eligible)
//   o_idx   - index of the granted requester
//   o_found - some requester was eligible
module oled_rr_pick
  import oled_pkg::*;
#(
  parameter int unsigned NREQ = OLED_NREQ,
  parameter int unsigned IW   = idx_width(NREQ)
) (
  input  logic [NREQ-1:0] i_elig,
  input  logic [IW-1:0]   i_last,
  output logic [NREQ-1:0] o_grant,
  output logic [IW-1:0]   o_idx,
  output logic            o_found
);

  logic [IW-1:0] w_cand;

  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    o_found = 1'b0;
    w_cand  = '0;
    // k = NREQ wraps back to i_last itself, so a lone eligible
    // requester that was also the last grant is still found.
    for (int unsigned k = 1; k <= NREQ; k++) begin
      w_cand = IW'((32'(i_last) + k) % NREQ);
      if (!o_found && i_elig[w_cand]) begin
        o_found         = 1'b1;
        o_grant[w_cand] = 1'b1;
        o_idx           = w_cand;
      end
    end
  end

endmodule

// File: rtl/oled_i2c_arb.sv
// oled_i2c_arb: round-robin arbiter sharing one I2C master between the
// OLED init sequencer (0), cursor/position (1) and pixel/char data (2).
//   clk, rst_n          - clock, asynchronous active-low reset
//   req_valid/lock/rh_wl, req_addr, req_data - packed per-requester request
//   req_ready           - one-cycle accept pulse (one-hot)
//   rsp_done            - one-cycle completion pulse (one-hot)
//   rsp_ack/err/data_r  - completion status, valid with rsp_done
//   i2c_exec/rh_wl/addr/data_w - command to the I2C master
//   i2c_data_r/done/ack - response from the I2C master
//   busy                - FSM not idle
//   timeout_cnt         - saturating count of aborted transactions
module oled_i2c_arb
  import oled_pkg::*;
#(
  parameter int unsigned NREQ       = OLED_NREQ,
  parameter int unsigned GAP_CYCLES = OLED_GAP_CYCLES,
  parameter int unsigned TIMEOUT    = OLED_TIMEOUT
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ-1:0]      req_lock,
  input  logic [NREQ-1:0]      req_rh_wl,
  input  logic [16*NREQ-1:0]   req_addr,
  input  logic [8*NREQ-1:0]    req_data,
  output logic [NREQ-1:0]      req_ready,
  output logic [NREQ-1:0]      rsp_done,
  output logic                 rsp_ack,
  output logic                 rsp_err,
  output logic [7:0]           rsp_data_r,
  output logic                 i2c_exec,
  output logic                 i2c_rh_wl,
  output logic [15:0]          i2c_addr,
  output logic [7:0]           i2c_data_w,
  input  logic [7:0]           i2c_data_r,
  input  logic                 i2c_done,
  input  logic                 i2c_ack,
  output logic                 busy,
  output logic [7:0]           timeout_cnt
);

  localparam int unsigned IW = idx_width(NREQ);
  localparam int unsigned GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GW-1:0]          GAP_LAST  = GW'(GAP_CYCLES - 1);
  localparam logic [OLED_WAIT_W-1:0] WAIT_LAST = OLED_WAIT_W'(TIMEOUT - 1);

  arb_state_t             r_state;
  logic [IW-1:0]          r_last;
  logic [NREQ-1:0]        r_gnt;
  logic                   r_lock_act;
  logic [NREQ-1:0]        r_lock_gnt;
  logic [OLED_WAIT_W-1:0] r_wait_cnt;
  logic [GW-1:0]          r_gap_cnt;
  logic [NREQ-1:0]        r_ready;
  logic [NREQ-1:0]        r_done;
  logic                   r_ack;
  logic                   r_err;
  logic [7:0]             r_data_r;
  logic                   r_exec;
  logic                   r_rh_wl;
  logic [15:0]            r_addr;
  logic [7:0]             r_data_w;
  logic                   r_busy;
  logic [7:0]             r_to_cnt;

  logic [NREQ-1:0]        w_elig;
  logic [NREQ-1:0]        w_gnt;
  logic [IW-1:0]          w_idx;
  logic                   w_found;
  logic [15:0]            w_sel_addr;
  logic [7:0]             w_sel_data;
  logic                   w_sel_rh_wl;

  // While a lock is held and its owner still asserts req_lock, only the
  // owner may win. The lock is released on the same IDLE cycle that
  // req_lock is seen low, so that cycle already arbitrates normally.
  always_comb begin
    w_elig = req_valid;
    if (r_lock_act && |(req_lock & r_lock_gnt)) begin
      w_elig = req_valid & r_lock_gnt;
    end
  end

  oled_rr_pick #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_pick (
    .i_elig  (w_elig),
    .i_last  (r_last),
    .o_grant (w_gnt),
    .o_idx   (w_idx),
    .o_found (w_found)
  );

  always_comb begin
    w_sel_addr  = '0;
    w_sel_data  = '0;
    w_sel_rh_wl = 1'b0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (w_gnt[i]) begin
        w_sel_addr  = req_addr[i*16 +: 16];
        w_sel_data  = req_data[i*8 +: 8];
        w_sel_rh_wl = req_rh_wl[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_last     <= IW'(NREQ - 1);
      r_gnt      <= '0;
      r_lock_act <= 1'b0;
      r_lock_gnt <= '0;
      r_wait_cnt <= '0;
      r_gap_cnt  <= '0;
      r_ready    <= '0;
      r_done     <= '0;
      r_ack      <= 1'b0;
      r_err      <= 1'b0;
      r_data_r   <= '0;
      r_exec     <= 1'b0;
      r_rh_wl    <= 1'b0;
      r_addr     <= '0;
      r_data_w   <= '0;
      r_busy     <= 1'b0;
      r_to_cnt   <= '0;
    end else begin
      r_ready <= '0;
      r_done  <= '0;
      r_exec  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (r_lock_act && !(|(req_lock & r_lock_gnt))) begin
            r_lock_act <= 1'b0;
          end
          if (w_found) begin
            r_ready  <= w_gnt;
            r_gnt    <= w_gnt;
            r_last   <= w_idx;
            r_addr   <= w_sel_addr;
            r_data_w <= w_sel_data;
            r_rh_wl  <= w_sel_rh_wl;
            r_busy   <= 1'b1;
            r_state  <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          r_exec     <= 1'b1;
          r_wait_cnt <= '0;
          r_state    <= ST_WAIT_DONE;
        end
        ST_WAIT_DONE: begin
          // Done takes priority over an expiring wait counter.
          if (i2c_done) begin
            r_done     <= r_gnt;
            r_ack      <= i2c_ack;
            r_data_r   <= i2c_data_r;
            r_err      <= 1'b0;
            r_lock_act <= |(req_lock & r_gnt);
            r_lock_gnt <= r_gnt;
            r_gap_cnt  <= '0;
            r_state    <= ST_GAP;
          end else if (r_wait_cnt == WAIT_LAST) begin
            r_done     <= r_gnt;
            r_ack      <= 1'b0;
            r_err      <= 1'b1;
            r_lock_act <= |(req_lock & r_gnt);
            r_lock_gnt <= r_gnt;
            if (r_to_cnt != 8'hFF) begin
              r_to_cnt <= r_to_cnt + 8'd1;
            end
            r_gap_cnt  <= '0;
            r_state    <= ST_GAP;
          end else begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
          end
        end
        ST_GAP: begin
          if (r_gap_cnt == GAP_LAST) begin
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end else begin
            r_gap_cnt <= r_gap_cnt + 1'b1;
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign req_ready   = r_ready;
  assign rsp_done    = r_done;
  assign rsp_ack     = r_ack;
  assign rsp_err     = r_err;
  assign rsp_data_r  = r_data_r;
  assign i2c_exec    = r_exec;
  assign i2c_rh_wl   = r_rh_wl;
  assign i2c_addr    = r_addr;
  assign i2c_data_w  = r_data_w;
  assign busy        = r_busy;
  assign timeout_cnt = r_to_cnt;

endmodule

// File: tb/tb_oled_i2c_arb.sv
// tb_oled_i2c_arb: directed self-checking bench for oled_i2c_arb.
module tb_oled_i2c_arb;
  import oled_pkg::*;

  localparam int unsigned NREQ = 3;
  localparam int unsigned GAP  = 16;
  localparam int unsigned TMO  = 5000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  req_valid, req_lock, req_rh_wl;
  logic [47:0] req_addr;
  logic [23:0] req_data;
  logic [2:0]  req_ready, rsp_done;
  logic        rsp_ack, rsp_err;
  logic [7:0]  rsp_data_r;
  logic        i2c_exec, i2c_rh_wl;
  logic [15:0] i2c_addr;
  logic [7:0]  i2c_data_w, i2c_data_r;
  logic        i2c_done, i2c_ack, busy;
  logic [7:0]  timeout_cnt;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  oled_i2c_arb #(
    .NREQ       (NREQ),
    .GAP_CYCLES (GAP),
    .TIMEOUT    (TMO)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_lock    (req_lock),
    .req_rh_wl   (req_rh_wl),
    .req_addr    (req_addr),
    .req_data    (req_data),
    .req_ready   (req_ready),
    .rsp_done    (rsp_done),
    .rsp_ack     (rsp_ack),
    .rsp_err     (rsp_err),
    .rsp_data_r  (rsp_data_r),
    .i2c_exec    (i2c_exec),
    .i2c_rh_wl   (i2c_rh_wl),
    .i2c_addr    (i2c_addr),
    .i2c_data_w  (i2c_data_w),
    .i2c_data_r  (i2c_data_r),
    .i2c_done    (i2c_done),
    .i2c_ack     (i2c_ack),
    .busy        (busy),
    .timeout_cnt (timeout_cnt)
  );

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic wait_ready(input int budget, output logic [2:0] g);
    g = '0;
    for (int n = 0; n < budget && g == 3'b000; n++) begin
      tick();
      g = req_ready;
    end
  endtask

  task automatic wait_exec(input int budget, output bit seen);
    seen = 1'b0;
    for (int n = 0; n < budget && !seen; n++) begin
      tick();
      seen = i2c_exec;
    end
  endtask

  task automatic finish_done(input logic ack, input logic [7:0] d);
    i2c_done   = 1'b1;
    i2c_ack    = ack;
    i2c_data_r = d;
    tick();
    i2c_done   = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) tick();
    checks++; if ({req_ready, rsp_done} !== 6'b0) begin errors++;
      $display("FAIL rst_pulses: got %b expected 000000", {req_ready, rsp_done}); end
    checks++; if ({rsp_ack, rsp_err, rsp_data_r, timeout_cnt} !== 18'b0) begin errors++;
      $display("FAIL rst_rsp: got %h expected 0", {rsp_ack, rsp_err, rsp_data_r, timeout_cnt}); end
    checks++; if ({i2c_exec, i2c_rh_wl, i2c_addr, i2c_data_w, busy} !== 27'b0) begin errors++;
      $display("FAIL rst_i2c: got %h expected 0", {i2c_exec, i2c_rh_wl, i2c_addr, i2c_data_w, busy}); end
    rst_n = 1'b1;
    repeat (2) tick();
    checks++; if ({busy, req_ready} !== 4'b0) begin errors++;
      $display("FAIL rst_idle: got %b expected 0000", {busy, req_ready}); end
  endtask

  task automatic test_single_write();
    req_addr[15:0] = OLED_CMD_ADDR;
    req_data[7:0]  = 8'hAE;
    req_rh_wl      = 3'b000;
    req_valid      = 3'b001;
    tick();
    checks++; if ({req_ready, i2c_exec, busy} !== 5'b00101) begin errors++;
      $display("FAIL sw_ready: got %b expected 00101", {req_ready, i2c_exec, busy}); end
    req_valid = 3'b000;
    tick();
    checks++; if ({i2c_exec, i2c_rh_wl, i2c_addr, i2c_data_w, req_ready} !== {2'b10, 16'h0000, 8'hAE, 3'b000}) begin errors++;
      $display("FAIL sw_exec: got %h expected %h", {i2c_exec, i2c_rh_wl, i2c_addr, i2c_data_w, req_ready},
               {2'b10, 16'h0000, 8'hAE, 3'b000}); end
    tick();
    checks++; if ({i2c_exec, i2c_addr, i2c_data_w} !== {1'b0, 16'h0000, 8'hAE}) begin errors++;
      $display("FAIL sw_hold: got %h expected %h", {i2c_exec, i2c_addr, i2c_data_w}, {1'b0, 16'h0000, 8'hAE}); end
    finish_done(1'b1, 8'h5A);
    checks++; if ({rsp_done, rsp_ack, rsp_err, rsp_data_r} !== {3'b001, 1'b1, 1'b0, 8'h5A}) begin errors++;
      $display("FAIL sw_done: got %h expected %h", {rsp_done, rsp_ack, rsp_err, rsp_data_r}, {3'b001, 2'b10, 8'h5A}); end
    tick();
    checks++; if (rsp_done !== 3'b000) begin errors++;
      $display("FAIL sw_done_pulse: got %b expected 000", rsp_done); end
    // stray done while in GAP must not produce a completion
    i2c_done = 1'b1;
    tick();
    i2c_done = 1'b0;
    checks++; if (rsp_done !== 3'b000) begin errors++;
      $display("FAIL gap_stray_done: got %b expected 000", rsp_done); end
    repeat (13) tick();
    checks++; if (busy !== 1'b1) begin errors++;
      $display("FAIL gap_len_busy: got %b expected 1", busy); end
    tick();
    checks++; if (busy !== 1'b0) begin errors++;
      $display("FAIL gap_len_idle: got %b expected 0", busy); end
  endtask

  task automatic test_round_robin();
    logic [2:0]  g;
    bit          seen;
    int          last_exec;
    logic [2:0]  exp_g    [4] = '{3'b001, 3'b010, 3'b100, 3'b001};
    logic [15:0] exp_addr [4] = '{16'h0000, 16'h0010, 16'h0040, 16'h0000};
    do_reset();
    req_addr  = {16'h0040, 16'h0010, 16'h0000};
    req_data  = {8'h33, 8'h22, 8'h11};
    req_valid = 3'b111;
    last_exec = 0;
    for (int t = 0; t < 4; t++) begin
      wait_ready(60, g);
      checks++; if (g !== exp_g[t]) begin errors++;
        $display("FAIL rr_grant%0d: got %b expected %b", t, g, exp_g[t]); end
      if (t == 3) req_valid = 3'b000;
      wait_exec(5, seen);
      checks++; if (!seen || i2c_addr !== exp_addr[t]) begin errors++;
        $display("FAIL rr_exec%0d: got seen=%0d addr=%h expected seen=1 addr=%h", t, seen, i2c_addr, exp_addr[t]); end
      // with an immediate done the exec-to-exec distance is exactly GAP+3
      if (t > 0) begin
        checks++; if (cyc - last_exec != int'(GAP) + 3) begin errors++;
          $display("FAIL rr_spacing%0d: got %0d expected %0d", t, cyc - last_exec, GAP + 3); end
      end
      last_exec = cyc;
      finish_done(1'b1, 8'(t));
      checks++; if (rsp_done !== exp_g[t]) begin errors++;
        $display("FAIL rr_done%0d: got %b expected %b", t, rsp_done, exp_g[t]); end
    end
  endtask

  task automatic test_lock();
    logic [2:0] g;
    bit         seen;
    int         stray;
    req_valid = 3'b110;
    req_lock  = 3'b010;
    for (int t = 0; t < 3; t++) begin
      wait_ready(60, g);
      checks++; if (g !== 3'b010) begin errors++;
        $display("FAIL lock_grant%0d: got %b expected 010", t, g); end
      wait_exec(5, seen);
      finish_done(1'b1, 8'h00);
    end
    // owner drops valid but keeps lock: requester 2 must keep waiting
    req_valid = 3'b100;
    stray = 0;
    for (int n = 0; n < 40; n++) begin
      tick();
      if (req_ready != 3'b000) stray++;
    end
    checks++; if (stray != 0) begin errors++;
      $display("FAIL lock_hold: got %0d grants expected 0", stray); end
    req_lock = 3'b000;
    tick();
    checks++; if (req_ready !== 3'b100) begin errors++;
      $display("FAIL lock_release: got %b expected 100", req_ready); end
    req_valid = 3'b000;
    wait_exec(5, seen);
    finish_done(1'b1, 8'h00);
    checks++; if (rsp_done !== 3'b100) begin errors++;
      $display("FAIL lock_release_done: got %b expected 100", rsp_done); end
  endtask

  task automatic test_timeout();
    logic [2:0] g;
    bit         seen;
    int         n;
    req_valid = 3'b001;
    wait_ready(60, g);
    req_valid = 3'b000;
    wait_exec(5, seen);
    i2c_ack = 1'b1;
    n = 0;
    for (int k = 1; k <= int'(TMO) + 20 && n == 0; k++) begin
      tick();
      if (rsp_done != 3'b000) n = k;
    end
    checks++; if (n != int'(TMO)) begin errors++;
      $display("FAIL to_latency: got %0d expected %0d", n, TMO); end
    checks++; if ({rsp_done, rsp_err, rsp_ack, timeout_cnt} !== {3'b001, 2'b10, 8'd1}) begin errors++;
      $display("FAIL to_resp: got %h expected %h", {rsp_done, rsp_err, rsp_ack, timeout_cnt}, {3'b001, 2'b10, 8'd1}); end
    req_valid = 3'b001;
    wait_ready(60, g);
    req_valid = 3'b000;
    checks++; if (g !== 3'b001) begin errors++;
      $display("FAIL to_next_grant: got %b expected 001", g); end
    wait_exec(5, seen);
    finish_done(1'b1, 8'hC3);
    checks++; if ({rsp_done, rsp_err, rsp_ack, rsp_data_r} !== {3'b001, 2'b01, 8'hC3}) begin errors++;
      $display("FAIL to_next_done: got %h expected %h", {rsp_done, rsp_err, rsp_ack, rsp_data_r}, {3'b001, 2'b01, 8'hC3}); end
  endtask

  task automatic test_done_at_limit();
    logic [2:0] g;
    bit         seen;
    req_valid = 3'b001;
    wait_ready(60, g);
    req_valid = 3'b000;
    wait_exec(5, seen);
    repeat (TMO - 1) tick();
    finish_done(1'b1, 8'h77);
    checks++; if ({rsp_done, rsp_err, rsp_ack, rsp_data_r, timeout_cnt} !== {3'b001, 2'b01, 8'h77, 8'd1}) begin errors++;
      $display("FAIL limit_done: got %h expected %h", {rsp_done, rsp_err, rsp_ack, rsp_data_r, timeout_cnt},
               {3'b001, 2'b01, 8'h77, 8'd1}); end
  endtask

  task automatic test_reset_mid();
    logic [2:0] g;
    bit         seen;
    int         dones;
    req_valid = 3'b010;
    wait_ready(60, g);
    req_valid = 3'b000;
    wait_exec(5, seen);
    repeat (5) tick();
    rst_n = 1'b0;
    dones = 0;
    tick();
    checks++; if ({busy, i2c_exec, i2c_addr, i2c_data_w, rsp_done, timeout_cnt, rsp_err} !== 37'b0) begin errors++;
      $display("FAIL mid_rst_outputs: got %h expected 0", {busy, i2c_exec, i2c_addr, i2c_data_w, rsp_done, timeout_cnt, rsp_err}); end
    req_valid = 3'b111;
    repeat (2) tick();
    rst_n = 1'b1;
    g = '0;
    for (int n = 0; n < 60 && g == 3'b000; n++) begin
      tick();
      if (rsp_done != 3'b000) dones++;
      g = req_ready;
    end
    req_valid = 3'b000;
    checks++; if (dones != 0) begin errors++;
      $display("FAIL mid_rst_no_done: got %0d expected 0", dones); end
    checks++; if (g !== 3'b001) begin errors++;
      $display("FAIL mid_rst_first: got %b expected 001", g); end
  endtask

  initial begin
    rst_n      = 1'b0;
    req_valid  = '0;
    req_lock   = '0;
    req_rh_wl  = '0;
    req_addr   = '0;
    req_data   = '0;
    i2c_data_r = '0;
    i2c_done   = 1'b0;
    i2c_ack    = 1'b0;
    test_reset();
    test_single_write();
    test_round_robin();
    test_lock();
    test_timeout();
    test_done_at_limit();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: got no finish expected finish before limit");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/oled_i2c_arb.md
OLED_I2C_ARB -- requirements
Module: oled_i2c_arb

Interface
REQ-001 Parameters, one per line: name, default, meaning.
- NREQ, 3, number of requesters; 0 = init sequencer, 1 = cursor/position, 2 = pixel/char data.
- GAP_CYCLES, 16, minimum idle cycles between a completion and the next i2c_exec.
- TIMEOUT, 5000, cycles allowed in WAIT_DONE before abort; counter is 14 bits.

REQ-002 Ports, one per line: name, direction, width, meaning. Reset is rst_n, asynchronous, active-low; the clock is clk.
- clk, in, 1, clock.
- rst_n, in, 1, reset.
- req_valid, in, NREQ, per-requester transaction request.
- req_lock, in, NREQ, keep the grant after completion (burst).
- req_rh_wl, in, NREQ, per-requester read-high/write-low.
- req_addr, in, 16*NREQ, packed; slice i = [16i+15:16i].
- req_data, in, 8*NREQ, packed write data.
- req_ready, out, NREQ, one-cycle accept pulse.
- rsp_done, out, NREQ, one-cycle completion pulse.
- rsp_ack, out, 1, ack of the completed transaction; valid with rsp_done.
- rsp_err, out, 1, timeout flag; valid with rsp_done.
- rsp_data_r, out, 8, read data; valid with rsp_done.
- i2c_exec, out, 1, master start pulse.
- i2c_rh_wl, out, 1, to the I2C master.
- i2c_addr, out, 16, to the I2C master.
- i2c_data_w, out, 8, to the I2C master.
- i2c_data_r, in, 8, from the I2C master.
- i2c_done, in, 1, from the I2C master.
- i2c_ack, in, 1, from the I2C master.
- busy, out, 1, high whenever state is not IDLE.
- timeout_cnt, out, 8, saturating count of aborts.

Function
REQ-003 The FSM SHALL have four states: IDLE, ISSUE, WAIT_DONE and GAP. All outputs SHALL be registered.

REQ-004 In IDLE, with any eligible req_valid at cycle t, the block SHALL grant g chosen round-robin, starting at (last_grant+1) mod NREQ.
- At t+1: req_ready[g]=1 for one cycle, req fields latched, state=ISSUE.

REQ-005 In ISSUE (t+1), the block SHALL drive i2c_exec=1 at t+2 for exactly one cycle with the latched addr/data/rh_wl, then go to WAIT_DONE.

REQ-006 i2c_addr, i2c_data_w and i2c_rh_wl SHALL hold their last latched value outside ISSUE.

REQ-007 In WAIT_DONE, i2c_done SHALL cause, on the next cycle:
- rsp_done[g]=1
- rsp_ack=i2c_ack
- rsp_data_r=i2c_data_r
- rsp_err=0
- state=GAP

REQ-008 In WAIT_DONE, if the wait counter reaches TIMEOUT-1 without i2c_done, the block SHALL abort with:
- rsp_done[g]=1
- rsp_err=1
- rsp_ack=0
- timeout_cnt incremented, saturating at 255
- state=GAP
If done and timeout occur in the same cycle, done wins.

REQ-009 i2c_done SHALL be ignored in IDLE, ISSUE and GAP.

REQ-010 GAP SHALL last exactly GAP_CYCLES cycles, then return to IDLE.

REQ-011 If req_lock[g]=1 at completion, only g SHALL be eligible in subsequent IDLE arbitration until req_lock[g] is sampled 0 in IDLE. The arbiter waits in IDLE even if other requesters are valid.

REQ-012 A requester dropping req_valid before req_ready SHALL lose its turn with no side effects. Arbitration SHALL be re-evaluated every IDLE cycle.

REQ-013 last_grant SHALL update only on the req_ready pulse. With NREQ valid simultaneously, grants SHALL rotate 0,1,2,0...

REQ-014 req_ready and rsp_done SHALL be one-hot or zero at all times.

Reset
REQ-015 On rst_n low, the block SHALL set:
- state=IDLE
- last_grant=NREQ-1, so requester 0 wins first
- i2c_exec, i2c_rh_wl, i2c_addr, i2c_data_w = 0
- req_ready, rsp_done, rsp_ack, rsp_err, rsp_data_r, timeout_cnt = 0
- lock cleared, all counters 0

REQ-016 Reset mid-transaction SHALL abandon the transaction without a rsp_done pulse.

Structure
REQ-017 Package oled_pkg SHALL hold:
- the state enum
- OLED_CMD_ADDR=16'h0000 and OLED_DATA_ADDR=16'h0040
- default GAP_CYCLES, TIMEOUT and NREQ

REQ-018 The round-robin selector SHALL be one combinational sub-module, oled_rr_pick, taking the eligible vector and last_grant and returning a one-hot grant and a found flag.

Verification
REQ-019 Single write: req_valid[0] with addr 16'h0000, data 8'hAE.
- req_ready[0] one cycle later, i2c_exec one cycle after that with addr 0000/AE.
- Done returned with ack=1 → rsp_done[0], rsp_ack=1.

REQ-020 Round-robin: all three valid continuously → grant order 0,1,2,0, with i2c_exec pulses separated by at least GAP_CYCLES+3 cycles.

REQ-021 Lock: req_lock[1]=1 for 3 transactions while req_valid[2] is held → three grants to 1, then 2 is granted on the first IDLE after lock drops.

REQ-022 Timeout: i2c_done is never asserted → rsp_done with rsp_err=1 exactly TIMEOUT cycles after entering WAIT_DONE; timeout_cnt=1; next request proceeds normally.

REQ-023 Stray/simultaneous done:
- i2c_done pulsed during GAP is ignored.
- done on the TIMEOUT-1 cycle → rsp_err=0.

REQ-024 Reset during WAIT_DONE → all outputs 0 and no rsp_done; after release, requester 0 wins first.
